multi_edge_counter: RTL and testbench

- Multi-channel, parametrised successor to the single-signal edge counter.
- Counts rising edges, falling edges or both on each of NUM_CH synchronous input signals. Each channel has its own mode select.
- Counters either wrap or saturate, and can be cleared globally.
- Atomic snapshot of all channels, read out over a valid/ready handshake. Used as the event-statistics block beside GPIO/status inputs.

---
 rtl/multi_edge_counter.sv | 90 +++++++++
 tb/tb_multi_edge_counter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_counter.sv
// multi_edge_counter: per-channel rise/fall/both edge counters with an atomic valid/ready snapshot.
// Define MULTI_EDGE_COUNTER_OVFL_EN to add sticky per-channel overflow flags (ovfl, snap_ovfl).
module multi_edge_counter #(
  parameter int NUM_CH        = 4,
  parameter int WIDTH         = 16,
  parameter int SATURATE      = 0,
  parameter int CLEAR_ON_SNAP = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         signal,
  input  logic [2*NUM_CH-1:0]       mode,
  input  logic                      clear,
  input  logic                      snap_req,
  output logic                      snap_valid,
  input  logic                      snap_ready,
  output logic [NUM_CH*WIDTH-1:0]   snap_data,
`ifdef MULTI_EDGE_COUNTER_OVFL_EN
  output logic [NUM_CH*WIDTH-1:0]   count,
  output logic [NUM_CH-1:0]         ovfl,
  output logic [NUM_CH-1:0]         snap_ovfl
`else
  output logic [NUM_CH*WIDTH-1:0]   count
`endif
);
  typedef enum logic {IDLE, HOLD} state_t;
  localparam logic [WIDTH-1:0] MAX = '1;
  state_t state_q, state_d;
  logic [NUM_CH*WIDTH-1:0] count_q, count_d, snap_data_q, snap_data_d;
  logic [NUM_CH-1:0] prev_q, inc, at_max;
  logic primed_q, accept;
  assign accept = state_q == IDLE && snap_req;
  always_comb begin
    inc = '0;
    at_max = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      inc[i] = primed_q & ((mode[2*i] & ~prev_q[i] & signal[i]) | (mode[2*i+1] & prev_q[i] & ~signal[i]));
      at_max[i] = count_q[i*WIDTH +: WIDTH] == MAX;
    end
  end
  // clear beats a snapshot restart, which beats the normal increment
  always_comb begin
    count_d = count_q;
    for (int i = 0; i < NUM_CH; i++)
      count_d[i*WIDTH +: WIDTH] = clear ? '0
        : (accept && CLEAR_ON_SNAP != 0) ? {{(WIDTH-1){1'b0}}, inc[i]}
        : (inc[i] && !(at_max[i] && SATURATE != 0)) ? count_q[i*WIDTH +: WIDTH] + 1'b1
        : count_q[i*WIDTH +: WIDTH];
  end
  always_comb begin
    state_d = accept ? HOLD : (state_q == HOLD && snap_ready) ? IDLE : state_q;
    snap_data_d = accept ? count_q : snap_data_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      snap_data_q <= '0;
      prev_q      <= '0;
      primed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      snap_data_q <= snap_data_d;
      prev_q      <= signal;
      primed_q    <= 1'b1;
    end
  end
  assign snap_valid = state_q == HOLD;
  assign snap_data  = snap_data_q;
  assign count      = count_q;
`ifdef MULTI_EDGE_COUNTER_OVFL_EN
  logic [NUM_CH-1:0] ovfl_q, ovfl_d, snap_ovfl_q, snap_ovfl_d;
  always_comb begin
    ovfl_d = (clear || (accept && CLEAR_ON_SNAP != 0)) ? '0 : ovfl_q | (inc & at_max);
    snap_ovfl_d = accept ? ovfl_q : snap_ovfl_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovfl_q      <= '0;
      snap_ovfl_q <= '0;
    end else begin
      ovfl_q      <= ovfl_d;
      snap_ovfl_q <= snap_ovfl_d;
    end
  end
  assign ovfl      = ovfl_q;
  assign snap_ovfl = snap_ovfl_q;
`endif
endmodule

// File: tb/tb_multi_edge_counter.sv
// tb_multi_edge_counter: directed vector table plus hand sequences over four parameterisations.
module tb_multi_edge_counter;
  logic clk = 1'b0, reset = 1'b0, clear = 1'b0, snap_req = 1'b0, snap_ready = 1'b0;
  logic [3:0] signal = 4'b0000;
  logic [7:0] mode = 8'h00;
  logic [63:0] count, snap_data, count_c, snap_data_c;
  logic [15:0] count_w, snap_data_w, count_s, snap_data_s;
  logic snap_valid, snap_valid_c, snap_valid_w, snap_valid_s;
`ifdef MULTI_EDGE_COUNTER_OVFL_EN
  logic [3:0] ovfl_d, sovfl_d, ovfl_c, sovfl_c, ovfl_w, sovfl_w, ovfl_s, sovfl_s;
`endif
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  multi_edge_counter dut (
    .clk(clk), .reset(reset), .signal(signal), .mode(mode), .clear(clear),
    .snap_req(snap_req), .snap_valid(snap_valid), .snap_ready(snap_ready), .snap_data(snap_data),
`ifdef MULTI_EDGE_COUNTER_OVFL_EN
    .ovfl(ovfl_d), .snap_ovfl(sovfl_d),
`endif
    .count(count));

  multi_edge_counter #(.CLEAR_ON_SNAP(1)) dut_c (
    .clk(clk), .reset(reset), .signal(signal), .mode(mode), .clear(clear),
    .snap_req(snap_req), .snap_valid(snap_valid_c), .snap_ready(snap_ready), .snap_data(snap_data_c),
`ifdef MULTI_EDGE_COUNTER_OVFL_EN
    .ovfl(ovfl_c), .snap_ovfl(sovfl_c),
`endif
    .count(count_c));

  multi_edge_counter #(.WIDTH(4), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .signal(signal), .mode(mode), .clear(clear),
    .snap_req(snap_req), .snap_valid(snap_valid_w), .snap_ready(snap_ready), .snap_data(snap_data_w),
`ifdef MULTI_EDGE_COUNTER_OVFL_EN
    .ovfl(ovfl_w), .snap_ovfl(sovfl_w),
`endif
    .count(count_w));

  multi_edge_counter #(.WIDTH(4), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .signal(signal), .mode(mode), .clear(clear),
    .snap_req(snap_req), .snap_valid(snap_valid_s), .snap_ready(snap_ready), .snap_data(snap_data_s),
`ifdef MULTI_EDGE_COUNTER_OVFL_EN
    .ovfl(ovfl_s), .snap_ovfl(sovfl_s),
`endif
    .count(count_s));

  typedef struct {
    logic [3:0]  sig;
    logic [7:0]  mode;
    logic [2:0]  ctl;
    logic [15:0] c0, c1;
    logic        vld;
    logic [15:0] s0, s1;
  } vec_t;
  vec_t tbl[20];

  function automatic vec_t mk(logic [3:0] s, logic [7:0] m, logic [2:0] ctl, logic [15:0] c0, logic [15:0] c1,
                              logic v, logic [15:0] s0, logic [15:0] s1);
    vec_t r;
    r.sig = s; r.mode = m; r.ctl = ctl; r.c0 = c0; r.c1 = c1; r.vld = v; r.s0 = s0; r.s1 = s1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    // ctl = {clear, snap_req, snap_ready}
    tbl[0]  = mk(4'b0000, 8'h09, 3'b000, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0);
    tbl[1]  = mk(4'b0011, 8'h09, 3'b000, 16'd1, 16'd0, 1'b0, 16'd0, 16'd0);
    tbl[2]  = mk(4'b0011, 8'h09, 3'b000, 16'd1, 16'd0, 1'b0, 16'd0, 16'd0);
    tbl[3]  = mk(4'b0000, 8'h09, 3'b000, 16'd1, 16'd1, 1'b0, 16'd0, 16'd0);
    tbl[4]  = mk(4'b0000, 8'h09, 3'b000, 16'd1, 16'd1, 1'b0, 16'd0, 16'd0);
    tbl[5]  = mk(4'b0011, 8'h09, 3'b000, 16'd2, 16'd1, 1'b0, 16'd0, 16'd0);
    tbl[6]  = mk(4'b0011, 8'h09, 3'b000, 16'd2, 16'd1, 1'b0, 16'd0, 16'd0);
    tbl[7]  = mk(4'b0010, 8'h03, 3'b000, 16'd3, 16'd1, 1'b0, 16'd0, 16'd0);
    tbl[8]  = mk(4'b0011, 8'h03, 3'b000, 16'd4, 16'd1, 1'b0, 16'd0, 16'd0);
    tbl[9]  = mk(4'b0010, 8'h03, 3'b000, 16'd5, 16'd1, 1'b0, 16'd0, 16'd0);
    tbl[10] = mk(4'b0010, 8'h03, 3'b010, 16'd5, 16'd1, 1'b1, 16'd5, 16'd1);
    tbl[11] = mk(4'b0011, 8'h03, 3'b010, 16'd6, 16'd1, 1'b1, 16'd5, 16'd1);
    tbl[12] = mk(4'b0010, 8'h03, 3'b010, 16'd7, 16'd1, 1'b1, 16'd5, 16'd1);
    tbl[13] = mk(4'b0011, 8'h03, 3'b000, 16'd8, 16'd1, 1'b1, 16'd5, 16'd1);
    tbl[14] = mk(4'b0011, 8'h03, 3'b011, 16'd8, 16'd1, 1'b0, 16'd5, 16'd1);
    tbl[15] = mk(4'b0011, 8'h03, 3'b010, 16'd8, 16'd1, 1'b1, 16'd8, 16'd1);
    tbl[16] = mk(4'b0011, 8'h03, 3'b001, 16'd8, 16'd1, 1'b0, 16'd8, 16'd1);
    tbl[17] = mk(4'b0010, 8'h03, 3'b110, 16'd0, 16'd0, 1'b1, 16'd8, 16'd1);
    tbl[18] = mk(4'b0010, 8'h03, 3'b001, 16'd0, 16'd0, 1'b0, 16'd8, 16'd1);
    tbl[19] = mk(4'b0011, 8'h03, 3'b000, 16'd1, 16'd0, 1'b0, 16'd8, 16'd1);

    repeat (3) tick();
    chk("reset count", count, 64'd0);
    chk("reset valid", {63'd0, snap_valid}, 64'd0);
    chk("reset snap_data", snap_data, 64'd0);
    reset = 1'b1;

    for (int k = 0; k < 20; k++) begin
      signal = tbl[k].sig;
      mode = tbl[k].mode;
      {clear, snap_req, snap_ready} = tbl[k].ctl;
      tick();
      chk($sformatf("v%0d count", k), count, {32'd0, tbl[k].c1, tbl[k].c0});
      chk($sformatf("v%0d valid", k), {63'd0, snap_valid}, {63'd0, tbl[k].vld});
      chk($sformatf("v%0d snap_data", k), snap_data, {32'd0, tbl[k].s1, tbl[k].s0});
    end
    {clear, snap_req, snap_ready} = 3'b000;

    // enter HOLD, then reset mid-HOLD with all inputs high
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    chk("hold valid", {63'd0, snap_valid}, 64'd1);
    chk("hold snap_data", snap_data, {32'd0, 16'd0, 16'd1});
    reset = 1'b0;
    signal = 4'b1111;
    mode = 8'hFF;
    tick();
    chk("midhold reset valid", {63'd0, snap_valid}, 64'd0);
    chk("midhold reset snap_data", snap_data, 64'd0);
    chk("midhold reset count", count, 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    chk("high at release count", count, 64'd0);
    signal = 4'b1110;
    tick();
    chk("first fall count", count, {48'd0, 16'd1});

    // 4-bit wrap versus saturate over 17 edges
    mode = 8'h03;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("w4 cleared", {48'd0, count_w}, 64'd0);
    chk("s4 cleared", {48'd0, count_s}, 64'd0);
    repeat (15) begin
      signal[0] = ~signal[0];
      tick();
    end
    chk("w4 at 15", {48'd0, count_w}, 64'h000F);
    chk("s4 at 15", {48'd0, count_s}, 64'h000F);
`ifdef MULTI_EDGE_COUNTER_OVFL_EN
    chk("w4 ovfl before", {60'd0, ovfl_w}, 64'd0);
    chk("s4 ovfl before", {60'd0, ovfl_s}, 64'd0);
`endif
    signal[0] = ~signal[0];
    tick();
    chk("w4 wrap 16", {48'd0, count_w}, 64'h0000);
    chk("s4 sat 16", {48'd0, count_s}, 64'h000F);
    signal[0] = ~signal[0];
    tick();
    chk("w4 wrap 17", {48'd0, count_w}, 64'h0001);
    chk("s4 sat 17", {48'd0, count_s}, 64'h000F);
`ifdef MULTI_EDGE_COUNTER_OVFL_EN
    chk("w4 ovfl after", {60'd0, ovfl_w}, 64'd1);
    chk("s4 ovfl after", {60'd0, ovfl_s}, 64'd1);
`endif

    // CLEAR_ON_SNAP: snapshot coinciding with an edge restarts at 1
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (9) begin
      signal[0] = ~signal[0];
      tick();
    end
    chk("cos count 9", count_c, {48'd0, 16'd9});
    signal[0] = ~signal[0];
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    chk("cos snap_data", snap_data_c, {48'd0, 16'd9});
    chk("cos count restart", count_c, {48'd0, 16'd1});
    chk("cos valid", {63'd0, snap_valid_c}, 64'd1);
    chk("plain snap_data", snap_data, {48'd0, 16'd9});
    chk("plain count", count, {48'd0, 16'd10});
    snap_ready = 1'b1;
    tick();
    snap_ready = 1'b0;
    chk("cos release valid", {63'd0, snap_valid_c}, 64'd0);
    chk("cos count after", count_c, {48'd0, 16'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
